// File: rtl/life_scan_ctrl.sv
// Upstream controller for the life-cell array: scan-chain load/readout,
// single-generation step and array clear, all issued through one command port.
module life_scan_ctrl #(
  parameter int CELLS = 64,
  parameter int WORD  = 8,
  parameter int GENW  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  input  logic [1:0]      i_cmd_op,
  output logic            o_cmd_ready,
  input  logic [WORD-1:0] i_in_data,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic [WORD-1:0] o_out_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  input  logic            i_chain_tail,
  output logic            o_scan,
  output logic            o_chain_head,
  output logic            o_write,
  output logic            o_val,
  output logic            o_enb,
  output logic            o_busy,
  output logic [GENW-1:0] o_gen_count
);

  localparam int BLW = $clog2(CELLS + 1);
  localparam int LCW = $clog2(WORD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_STEP,
    S_CLEAR
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [BLW-1:0]  r_bits_left;
  logic [WORD-1:0] r_load_buf;
  logic [LCW-1:0]  r_load_cnt;
  logic [WORD-1:0] r_rd_buf;
  logic [LCW-1:0]  r_rd_k;
  logic            r_out_valid;
  logic [GENW-1:0] r_gen_count;

  logic w_cmd_accept;
  logic w_in_ready;
  logic w_load_accept;
  logic w_load_shift;
  logic w_read_shift;
  logic w_read_last;
  logic w_read_hs;

  assign w_cmd_accept  = (r_state == S_IDLE) && i_cmd_valid;
  assign w_in_ready    = (r_state == S_LOAD) && (r_load_cnt == '0) && (r_bits_left != '0);
  assign w_load_accept = w_in_ready && i_in_valid;
  assign w_load_shift  = (r_state == S_LOAD) && (r_load_cnt != '0);
  assign w_read_shift  = (r_state == S_READ) && !r_out_valid && (r_bits_left != '0);
  // A readout word closes when it is full or when the chain has no bits left.
  assign w_read_last   = w_read_shift &&
                         ((r_rd_k == LCW'(WORD - 1)) || (r_bits_left == BLW'(1)));
  assign w_read_hs     = (r_state == S_READ) && r_out_valid && i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_scan       = 1'b0;
    o_chain_head = 1'b0;
    o_write      = 1'b0;
    o_enb        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd_op)
            2'b00:   w_next_state = S_LOAD;
            2'b01:   w_next_state = S_READ;
            2'b10:   w_next_state = S_STEP;
            default: w_next_state = S_CLEAR;
          endcase
        end
      end
      S_LOAD: begin
        if (w_load_shift) begin
          o_scan       = 1'b1;
          o_chain_head = r_load_buf[0];
          if (r_bits_left == BLW'(1)) begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_READ: begin
        // Recirculating the tail back into the head keeps the readout nondestructive.
        if (w_read_shift) begin
          o_scan       = 1'b1;
          o_chain_head = i_chain_tail;
        end
        if (w_read_hs && (r_bits_left == '0)) begin
          w_next_state = S_IDLE;
        end
      end
      S_STEP: begin
        o_enb        = 1'b1;
        w_next_state = S_IDLE;
      end
      S_CLEAR: begin
        o_write      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bits_left <= '0;
      r_load_buf  <= '0;
      r_load_cnt  <= '0;
      r_rd_buf    <= '0;
      r_rd_k      <= '0;
      r_out_valid <= 1'b0;
      r_gen_count <= '0;
    end else begin
      if (w_cmd_accept) begin
        r_bits_left <= BLW'(CELLS);
        r_load_buf  <= '0;
        r_load_cnt  <= '0;
        r_rd_buf    <= '0;
        r_rd_k      <= '0;
        r_out_valid <= 1'b0;
      end

      // Only as many bits as the chain still needs are counted; surplus high bits are dropped.
      if (w_load_accept) begin
        r_load_buf <= i_in_data;
        r_load_cnt <= (r_bits_left >= BLW'(WORD)) ? LCW'(WORD) : LCW'(r_bits_left);
      end else if (w_load_shift) begin
        r_load_buf  <= r_load_buf >> 1;
        r_load_cnt  <= r_load_cnt - LCW'(1);
        r_bits_left <= r_bits_left - BLW'(1);
      end

      if (w_read_shift) begin
        r_rd_buf    <= r_rd_buf | (WORD'(i_chain_tail) << r_rd_k);
        r_rd_k      <= r_rd_k + LCW'(1);
        r_bits_left <= r_bits_left - BLW'(1);
        if (w_read_last) begin
          r_out_valid <= 1'b1;
        end
      end

      if (w_read_hs) begin
        r_out_valid <= 1'b0;
        r_rd_buf    <= '0;
        r_rd_k      <= '0;
      end

      if (r_state == S_STEP) begin
        r_gen_count <= r_gen_count + GENW'(1);
      end else if (r_state == S_CLEAR) begin
        r_gen_count <= '0;
      end
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_in_ready  = w_in_ready;
  assign o_out_data  = r_rd_buf;
  assign o_out_valid = r_out_valid;
  assign o_val       = 1'b0;
  assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_life_scan_ctrl.sv
// Bench for life_scan_ctrl: three parameterisations share one stimulus port,
// each driving a behavioural model of the cell array attached to its scan chain.
module tb_life_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  always #5 clk = ~clk;

  logic        aCmdReady, aInReady, aOutValid, aScan, aHead, aWrite, aVal, aEnb, aBusy;
  logic [7:0]  aOutData;
  logic [15:0] aGen;
  logic        bCmdReady, bInReady, bOutValid, bScan, bHead, bWrite, bVal, bEnb, bBusy;
  logic [7:0]  bOutData;
  logic [15:0] bGen;
  logic        cCmdReady, cInReady, cOutValid, cScan, cHead, cWrite, cVal, cEnb, cBusy;
  logic [1:0]  cOutData;
  logic [3:0]  cGen;

  logic [63:0] arrA = '0;
  logic [9:0]  arrB = '0;
  logic [3:0]  arrC = '0;

  life_scan_ctrl #(.CELLS(64), .WORD(8), .GENW(16)) dutA (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid && (sel == 2'd0)), .i_cmd_op(cmd_op), .o_cmd_ready(aCmdReady),
    .i_in_data(in_data), .i_in_valid(in_valid && (sel == 2'd0)), .o_in_ready(aInReady),
    .o_out_data(aOutData), .o_out_valid(aOutValid), .i_out_ready(out_ready && (sel == 2'd0)),
    .i_chain_tail(arrA[63]), .o_scan(aScan), .o_chain_head(aHead), .o_write(aWrite),
    .o_val(aVal), .o_enb(aEnb), .o_busy(aBusy), .o_gen_count(aGen)
  );

  life_scan_ctrl #(.CELLS(10), .WORD(8), .GENW(16)) dutB (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid && (sel == 2'd1)), .i_cmd_op(cmd_op), .o_cmd_ready(bCmdReady),
    .i_in_data(in_data), .i_in_valid(in_valid && (sel == 2'd1)), .o_in_ready(bInReady),
    .o_out_data(bOutData), .o_out_valid(bOutValid), .i_out_ready(out_ready && (sel == 2'd1)),
    .i_chain_tail(arrB[9]), .o_scan(bScan), .o_chain_head(bHead), .o_write(bWrite),
    .o_val(bVal), .o_enb(bEnb), .o_busy(bBusy), .o_gen_count(bGen)
  );

  life_scan_ctrl #(.CELLS(4), .WORD(2), .GENW(4)) dutC (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid && (sel == 2'd2)), .i_cmd_op(cmd_op), .o_cmd_ready(cCmdReady),
    .i_in_data(in_data[1:0]), .i_in_valid(in_valid && (sel == 2'd2)), .o_in_ready(cInReady),
    .o_out_data(cOutData), .o_out_valid(cOutValid), .i_out_ready(out_ready && (sel == 2'd2)),
    .i_chain_tail(arrC[3]), .o_scan(cScan), .o_chain_head(cHead), .o_write(cWrite),
    .o_val(cVal), .o_enb(cEnb), .o_busy(cBusy), .o_gen_count(cGen)
  );

  // Observed outputs of whichever instance is currently selected.
  logic        cmdReady, inReady, outValid, scan, write, val, enb, busy;
  logic [7:0]  outData;
  logic [15:0] gen;
  logic [63:0] curArr;

  always_comb begin
    cmdReady = aCmdReady; inReady = aInReady; outValid = aOutValid; scan = aScan;
    write = aWrite; val = aVal; enb = aEnb; busy = aBusy; outData = aOutData;
    gen = aGen; curArr = arrA;
    if (sel == 2'd1) begin
      cmdReady = bCmdReady; inReady = bInReady; outValid = bOutValid; scan = bScan;
      write = bWrite; val = bVal; enb = bEnb; busy = bBusy; outData = bOutData;
      gen = bGen; curArr = {54'd0, arrB};
    end else if (sel == 2'd2) begin
      cmdReady = cCmdReady; inReady = cInReady; outValid = cOutValid; scan = cScan;
      write = cWrite; val = cVal; enb = cEnb; busy = cBusy; outData = {6'd0, cOutData};
      gen = {12'd0, cGen}; curArr = {60'd0, arrC};
    end
  end

  // Array index r*8+c on an 8x8 torus; index 0 is the head cell, 63 the tail.
  function automatic logic [63:0] lifeStep(input logic [63:0] g);
    logic [63:0] nxt;
    int n;
    nxt = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              n += int'(g[((r + dr + 8) % 8) * 8 + ((c + dc + 8) % 8)]);
            end
          end
        end
        nxt[r * 8 + c] = (n == 3) || (g[r * 8 + c] && (n == 2));
      end
    end
    return nxt;
  endfunction

  always @(posedge clk) begin
    if (aWrite)     arrA <= {64{aVal}};
    else if (aEnb)  arrA <= lifeStep(arrA);
    else if (aScan) arrA <= {arrA[62:0], aHead};
  end

  always @(posedge clk) begin
    if (bWrite)     arrB <= {10{bVal}};
    else if (bScan) arrB <= {arrB[8:0], bHead};
  end

  always @(posedge clk) begin
    if (cWrite)     arrC <= {4{cVal}};
    else if (cScan) arrC <= {arrC[2:0], cHead};
  end

  int scanCount = 0;
  always @(posedge clk) begin
    if (scan) scanCount <= scanCount + 1;
  end

  int passCount  = 0;
  int checkCount = 0;

  logic [7:0] wordsBuf [16];
  logic [7:0] expBuf   [16];

  typedef struct {
    logic [1:0]  op;
    logic        expEnb;
    logic        expWrite;
    logic [15:0] expGen;
  } vec_t;
  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic timeoutFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: wait expired, condition never reached (expected within budget)", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCmdReady(input string name);
    int n = 0;
    while (!cmdReady && n < 300) begin tick(); n++; end
    if (!cmdReady) timeoutFail(name);
  endtask

  task automatic waitInReady(input string name);
    int n = 0;
    while (!inReady && n < 300) begin tick(); n++; end
    if (!inReady) timeoutFail(name);
  endtask

  task automatic waitOutValid(input string name);
    int n = 0;
    while (!outValid && n < 300) begin tick(); n++; end
    if (!outValid) timeoutFail(name);
  endtask

  task automatic applyStimulus(input logic [1:0] op);
    waitCmdReady("cmd_ready_wait");
    cmd_op    = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expected array after a full load: stream bit j lands at index cells-1-j.
  function automatic logic [63:0] streamToArray(input int cells, input int wordW);
    logic [63:0] res;
    res = '0;
    for (int j = 0; j < cells; j++) res[cells - 1 - j] = wordsBuf[j / wordW][j % wordW];
    return res;
  endfunction

  task automatic loadWords(input int nW, input int gap, input int cells);
    int base;
    applyStimulus(2'b00);
    base = scanCount;
    for (int w = 0; w < nW; w++) begin
      waitInReady("load_in_ready");
      for (int g = 0; g < gap; g++) begin
        checkOutput("load_gap_scan", 64'(scan), 64'd0);
        tick();
      end
      in_data  = wordsBuf[w];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    waitCmdReady("load_done");
    checkOutput("load_scan_count", 64'(scanCount - base), 64'(cells));
  endtask

  task automatic readWords(input int nW, input int stall, input int cells);
    int base;
    applyStimulus(2'b01);
    base      = scanCount;
    out_ready = 1'b0;
    for (int w = 0; w < nW; w++) begin
      waitOutValid("read_out_valid");
      for (int s = 0; s < stall; s++) begin
        checkOutput("read_stall_scan", 64'(scan), 64'd0);
        checkOutput("read_stall_valid", 64'(outValid), 64'd1);
        checkOutput("read_stall_data", 64'(outData), 64'(expBuf[w]));
        tick();
      end
      checkOutput("read_word", 64'(outData), 64'(expBuf[w]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    waitCmdReady("read_done");
    checkOutput("read_scan_count", 64'(scanCount - base), 64'(cells));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks so far %0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] pat;
    int base;

    vecs[0] = '{2'b11, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{2'b10, 1'b1, 1'b0, 16'd1};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 16'd2};
    vecs[3] = '{2'b10, 1'b1, 1'b0, 16'd3};
    vecs[4] = '{2'b11, 1'b0, 1'b1, 16'd0};
    vecs[5] = '{2'b10, 1'b1, 1'b0, 16'd1};

    rst_n = 1'b0; sel = 2'd0; cmd_valid = 1'b0; cmd_op = 2'b00;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 64'(cmdReady), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_scan", 64'(scan), 64'd0);
    checkOutput("rst_in_ready", 64'(inReady), 64'd0);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_out_data", 64'(outData), 64'd0);
    checkOutput("rst_enb_write", 64'({enb, write, val}), 64'd0);
    checkOutput("rst_gen", 64'(gen), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] 64 cells: load 0x01..0x08 then read back");
    for (int w = 0; w < 8; w++) wordsBuf[w] = 8'(w + 1);
    for (int w = 0; w < 8; w++) expBuf[w] = 8'(w + 1);
    loadWords(8, 0, 64);
    checkOutput("a_load_array", curArr, streamToArray(64, 8));
    readWords(8, 0, 64);
    checkOutput("a_read_array", curArr, streamToArray(64, 8));

    $display("[TB] 64 cells: input gaps and output stalls");
    wordsBuf[0] = 8'hA5; wordsBuf[1] = 8'h3C; wordsBuf[2] = 8'hF0; wordsBuf[3] = 8'h0F;
    wordsBuf[4] = 8'h81; wordsBuf[5] = 8'h7E; wordsBuf[6] = 8'h55; wordsBuf[7] = 8'hC3;
    for (int w = 0; w < 8; w++) expBuf[w] = wordsBuf[w];
    loadWords(8, 3, 64);
    checkOutput("a_gap_array", curArr, streamToArray(64, 8));
    readWords(8, 5, 64);
    checkOutput("a_stall_array", curArr, streamToArray(64, 8));

    $display("[TB] 10 cells: partial final word");
    sel = 2'd1;
    wordsBuf[0] = 8'hFF; wordsBuf[1] = 8'hFF;
    expBuf[0] = 8'hFF; expBuf[1] = 8'h03;
    loadWords(2, 0, 10);
    checkOutput("b_load_array", curArr, 64'h3FF);
    readWords(2, 0, 10);
    checkOutput("b_read_array", curArr, 64'h3FF);

    $display("[TB] 4 cells, 2-bit words, 4-bit generation counter");
    sel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].op);
      checkOutput("c_vec_enb", 64'(enb), 64'(vecs[i].expEnb));
      checkOutput("c_vec_write", 64'(write), 64'(vecs[i].expWrite));
      checkOutput("c_vec_busy", 64'(busy), 64'd1);
      tick();
      checkOutput("c_vec_gen", 64'(gen), 64'(vecs[i].expGen));
      checkOutput("c_vec_idle", 64'({cmdReady, enb, write}), 64'b100);
    end
    applyStimulus(2'b11);
    tick();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(2'b10);
      tick();
    end
    checkOutput("c_gen_max", 64'(gen), 64'd15);
    applyStimulus(2'b10);
    tick();
    checkOutput("c_gen_wrap", 64'(gen), 64'd0);
    wordsBuf[0] = 8'h01; wordsBuf[1] = 8'h02;
    expBuf[0] = 8'h01; expBuf[1] = 8'h02;
    loadWords(2, 0, 4);
    checkOutput("c_load_array", curArr, 64'h9);
    readWords(2, 0, 4);
    checkOutput("c_read_array", curArr, 64'h9);

    $display("[TB] 64 cells: blinker, two steps, readback, clear");
    sel = 2'd0;
    pat = 64'h0000_0000_1C00_0000;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 8; b++) wordsBuf[w][b] = pat[63 - (w * 8 + b)];
    for (int w = 0; w < 8; w++) expBuf[w] = wordsBuf[w];
    loadWords(8, 0, 64);
    checkOutput("blink_load_array", curArr, pat);
    applyStimulus(2'b10);
    checkOutput("blink_step1_enb", 64'(enb), 64'd1);
    tick();
    checkOutput("blink_step1_enb_off", 64'(enb), 64'd0);
    checkOutput("blink_step1_gen", 64'(gen), 64'd1);
    checkOutput("blink_step1_array", curArr, 64'h0000_0008_0808_0000);
    applyStimulus(2'b10);
    checkOutput("blink_step2_enb", 64'(enb), 64'd1);
    tick();
    checkOutput("blink_step2_enb_off", 64'(enb), 64'd0);
    checkOutput("blink_step2_gen", 64'(gen), 64'd2);
    checkOutput("blink_step2_array", curArr, pat);
    readWords(8, 0, 64);
    checkOutput("blink_read_array", curArr, pat);
    applyStimulus(2'b11);
    checkOutput("clear_write", 64'({write, val, enb}), 64'b100);
    tick();
    checkOutput("clear_write_off", 64'(write), 64'd0);
    checkOutput("clear_gen", 64'(gen), 64'd0);
    checkOutput("clear_array", curArr, 64'd0);

    $display("[TB] 64 cells: reset during shift 20 of a load");
    for (int w = 0; w < 8; w++) wordsBuf[w] = 8'h11;
    applyStimulus(2'b00);
    base = scanCount;
    for (int w = 0; w < 3; w++) begin
      waitInReady("abort_in_ready");
      in_data  = wordsBuf[w];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    for (int n = 0; n < 100 && (scanCount - base) < 19; n++) tick();
    checkOutput("abort_shift_index", 64'(scanCount - base), 64'd19);
    checkOutput("abort_pre_scan", 64'(scan), 64'd1);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    checkOutput("abort_scan", 64'(scan), 64'd0);
    checkOutput("abort_in_ready", 64'(inReady), 64'd0);
    checkOutput("abort_cmd_ready", 64'(cmdReady), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("abort_idle_after", 64'({cmdReady, busy, scan}), 64'b100);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
